vita49_clk_disc: RTL
====================

Name: vita49_clk_disc

Overview:
- Parametrised, PPS-disciplined VITA-49 timestamp generator for one sample-clock domain.
- Maintains the integer-seconds count (TSI) and the fractional sample count (TSF).
- Adds three behaviours:
  - Holdover: internal rollover when PPS is missing.
  - Free-run mode.
  - PPS period checking with lock status.
- Also provides TSI programming armed to the next epoch and a coherent snapshot for processor readback.
- Instantiate one per sample-clock domain; it feeds the packetisers and the register bank.

Parameters:
- TSI_W, 32, width of the integer-seconds counter.
- TSF_W, 64, width of the fractional sample counter.
- SAMP_PER_SEC, 61440000, nominal samples per PPS period. Must be less than 2^TSF_W and greater than PPS_TOL.
- PPS_TOL, 16, allowed period error, in samples.
- LOCK_CNT, 3, number of consecutive good periods required to assert lock. Must be at least 1.
- ERR_W, 8, width of the saturating PPS error counter.

Ports:
- samp_clk  in  1  sample clock; sole clock.
- ARESETN  in  1  asynchronous active-low reset.
- pps  in  1  raw PPS input, asynchronous.
- en  in  1  count enable (level).
- clr  in  1  synchronous clear (level).
- freerun  in  1  1 = ignore PPS for timing, wrap internally.
- set_tsi  in  1  single-cycle pulse: load tsi_prog.
- tsi_prog  in  TSI_W  programmed seconds value.
- snap_req  in  1  single-cycle pulse: capture tsi/tsf.
- err_clr  in  1  single-cycle pulse: clear sticky flags and err_cnt.
- tsi  out  TSI_W  live integer seconds.
- tsf  out  TSF_W  live fractional count.
- epoch  out  1  single-cycle pulse on the cycle tsf restarts at 0.
- snap_tsi  out  TSI_W  captured TSI.
- snap_tsf  out  TSF_W  captured TSF.
- snap_valid  out  1  single-cycle pulse when the snapshot is updated.
- armed  out  1  set_tsi is pending until the next epoch.
- pps_lock  out  1  PPS is within tolerance for LOCK_CNT consecutive periods.
- pps_err  out  1  sticky: PPS period out of tolerance.
- pps_miss  out  1  sticky: holdover rollover occurred.
- err_cnt  out  ERR_W  saturating count of bad or missing periods.

Behaviour:
- Reset: every register and every output is 0.
- PPS synchroniser:
  - Two flops, then an edge register.
  - pps_rise is asserted 3 clocks after the pin's rising edge.
  - pps_rise is always computed, independent of en.
- Priority each cycle: clr > (en==0 path) > counting.
- clr:
  - Zeroes tsi, tsf, the pending register, armed, pps_lock, the good-period counter, the sticky flags and err_cnt.
  - Takes effect the next cycle.
- en==0:
  - tsi and tsf hold.
  - set_tsi loads tsi_prog into tsi immediately, on the next cycle; armed stays 0.
- en==1:
  - set_tsi latches tsi_prog into the pending register and sets armed.
  - A second set_tsi before the epoch overwrites the pending value.
- Epoch sources, with en==1:
  - Disciplined (freerun=0): pps_rise, or holdover when tsf == SAMP_PER_SEC+PPS_TOL-1 without pps_rise.
  - Freerun=1: tsf == SAMP_PER_SEC-1. PPS edges are ignored for timing but the period check still runs.
- On an epoch cycle:
  - tsf <= 0.
  - tsi <= pending if armed, else tsi+1. Modulo 2^TSI_W wrap.
  - armed <= 0.
  - epoch = 1 registered with the update.
- Otherwise, with en==1: tsf <= tsf+1, wrapping modulo 2^TSF_W.
- Period check, on each pps_rise with en==1:
  - Period P = tsf+1.
  - Good if |P − SAMP_PER_SEC| ≤ PPS_TOL: the good counter increments, saturating at LOCK_CNT; pps_lock = (counter == LOCK_CNT).
  - Bad: pps_err <= 1, err_cnt +1 saturating, good counter <= 0, pps_lock <= 0.
- First pps_rise after en rises or after clr:
  - Aligns only; no period check.
  - In disciplined mode it still forces an epoch.
- Holdover rollover:
  - pps_miss <= 1, err_cnt +1, pps_lock <= 0, good counter <= 0.
  - The check-skip rule re-arms, so the next pps_rise only aligns.
- Simultaneous events:
  - set_tsi on an epoch cycle: the epoch uses the prior pending/armed state; the new request arms for the next epoch.
  - snap_req on an epoch cycle captures the pre-update values.
  - err_clr together with a new error: the error wins.
- Snapshot:
  - snap_tsi and snap_tsf register the tsi and tsf values present in the snap_req cycle.
  - snap_valid pulses 1 cycle later; the values hold until the next request.
  - Works with en=0.
- Asynchronous ARESETN assertion mid-second clears everything immediately. Counting resumes from 0 after deassertion.

Decomposition:
- Package vita49_clk_pkg:
  - Default widths: TSI_W, TSF_W, ERR_W.
  - Status bit indices for the register map: armed, lock, err, miss.
  - Mode enum: DISC, FREERUN.
- Sub-module vita49_pps_sync: two-flop synchroniser plus rising-edge pulse, with asynchronous active-low reset.

Test Plan (SAMP_PER_SEC=100, PPS_TOL=2, LOCK_CNT=3):
- Disciplined locking: en=1, PPS every 100 clks → tsi increments once per PPS, tsf restarts at 0 three clocks after each pin edge, pps_lock=1 after the 4th pps_rise (first one only aligns), pps_err=0.
- Tolerance edges: PPS at periods 98 and 102 → no error; then a period of 103 → pps_err=1, err_cnt=1, pps_lock=0; err_clr → pps_err=0, err_cnt=0.
- Holdover and free-run: stop PPS after lock → rollover at tsf=101, tsi+1, pps_miss=1, epoch pulse; freerun=1 → tsf wraps at 99 regardless of PPS at period 150.
- Armed programming: set_tsi with tsi_prog=0x1234 mid-second → armed=1, tsi unchanged until the next epoch, then tsi=0x1234 and armed=0; set_tsi with en=0 → tsi=0x1234 on the next cycle.
- Coherent snapshot: snap_req on the epoch cycle with tsi=7, tsf=99 → snap_tsi=7, snap_tsf=99, snap_valid one cycle later; live tsi=8, tsf=0.
- Reset and clr: ARESETN low mid-second → all outputs 0 at once; clr with err_cnt at 255 (ERR_W=8, saturation checked) → everything 0 next cycle.

Source files
------------

// File: rtl/vita49_clk_pkg.sv
// Shared widths, register-map status bit positions and timing-mode encoding
// for the VITA-49 PPS-disciplined timestamp generator.
package vita49_clk_pkg;

  localparam int unsigned TSI_W_DEF = 32;
  localparam int unsigned TSF_W_DEF = 64;
  localparam int unsigned ERR_W_DEF = 8;

  localparam int unsigned STAT_ARMED = 0;
  localparam int unsigned STAT_LOCK  = 1;
  localparam int unsigned STAT_ERR   = 2;
  localparam int unsigned STAT_MISS  = 3;
  localparam int unsigned STAT_W     = 4;

  typedef enum logic {
    DISC    = 1'b0,
    FREERUN = 1'b1
  } mode_e;

  // Packs the status flags into the register-bank status word layout.
  function automatic logic [STAT_W-1:0] pack_status(input logic armed,
                                                    input logic lock,
                                                    input logic err,
                                                    input logic miss);
    logic [STAT_W-1:0] s;
    s             = '0;
    s[STAT_ARMED] = armed;
    s[STAT_LOCK]  = lock;
    s[STAT_ERR]   = err;
    s[STAT_MISS]  = miss;
    return s;
  endfunction

endpackage

// File: rtl/vita49_clk_disc_if.sv
// Control and status bundle between the timestamp generator and its users
// (register bank drives controls, packetisers/register bank read status).
interface vita49_clk_disc_if #(
  parameter int unsigned TSI_W = vita49_clk_pkg::TSI_W_DEF,
  parameter int unsigned TSF_W = vita49_clk_pkg::TSF_W_DEF,
  parameter int unsigned ERR_W = vita49_clk_pkg::ERR_W_DEF
);

  logic             en;
  logic             clr;
  logic             freerun;
  logic             set_tsi;
  logic [TSI_W-1:0] tsi_prog;
  logic             snap_req;
  logic             err_clr;

  logic [TSI_W-1:0] tsi;
  logic [TSF_W-1:0] tsf;
  logic             epoch;
  logic [TSI_W-1:0] snap_tsi;
  logic [TSF_W-1:0] snap_tsf;
  logic             snap_valid;
  logic             armed;
  logic             pps_lock;
  logic             pps_err;
  logic             pps_miss;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, clr, freerun, set_tsi, tsi_prog, snap_req, err_clr,
    input  tsi, tsf, epoch, snap_tsi, snap_tsf, snap_valid,
           armed, pps_lock, pps_err, pps_miss, err_cnt
  );

  modport slave (
    input  en, clr, freerun, set_tsi, tsi_prog, snap_req, err_clr,
    output tsi, tsf, epoch, snap_tsi, snap_tsf, snap_valid,
           armed, pps_lock, pps_err, pps_miss, err_cnt
  );

endinterface

// File: rtl/vita49_pps_sync.sv
// Two-flop synchroniser for the asynchronous PPS pin plus a rising-edge detect;
// pps_rise is high during the third sample-clock cycle after the pin edge.
module vita49_pps_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pps,
  output logic pps_rise
);

  logic meta_q;
  logic sync_q;
  logic edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      meta_q <= pps;
      sync_q <= meta_q;
      edge_q <= sync_q;
    end
  end

  assign pps_rise = sync_q & ~edge_q;

endmodule

// File: rtl/vita49_clk_disc.sv
// PPS-disciplined VITA-49 TSI/TSF timestamp generator with holdover, free-run,
// PPS period checking/lock, epoch-armed TSI programming and coherent snapshot.
module vita49_clk_disc
  import vita49_clk_pkg::*;
#(
  parameter int unsigned TSI_W        = TSI_W_DEF,
  parameter int unsigned TSF_W        = TSF_W_DEF,
  parameter int unsigned SAMP_PER_SEC = 61440000,
  parameter int unsigned PPS_TOL      = 16,
  parameter int unsigned LOCK_CNT     = 3,
  parameter int unsigned ERR_W        = ERR_W_DEF
) (
  input logic              samp_clk,
  input logic              ARESETN,
  input logic              pps,
  vita49_clk_disc_if.slave bus
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

  // tsf values that end a nominal second, the tolerance window and holdover.
  localparam logic [TSF_W-1:0] NOM_LAST  = TSF_W'(SAMP_PER_SEC - 1);
  localparam logic [TSF_W-1:0] HOLD_LAST = TSF_W'(SAMP_PER_SEC + PPS_TOL - 1);
  localparam logic [TSF_W-1:0] WIN_LO    = TSF_W'(SAMP_PER_SEC - PPS_TOL - 1);
  localparam logic [TSF_W-1:0] WIN_HI    = HOLD_LAST;

  logic              pps_rise;

  logic [TSI_W-1:0]  tsi_q;
  logic [TSF_W-1:0]  tsf_q;
  logic [TSI_W-1:0]  pend_q;
  logic              armed_q;
  logic              epoch_q;

  logic [TSI_W-1:0]  snap_tsi_q;
  logic [TSF_W-1:0]  snap_tsf_q;
  logic              snap_valid_q;

  logic              lock_q;
  logic              err_q;
  logic              miss_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic [GOOD_W-1:0] good_q;
  logic              aligned_q;

  mode_e             mode;
  logic              epoch_now;
  logic              holdover;
  logic              period_ok;
  logic [ERR_W-1:0]  err_base;
  logic [ERR_W-1:0]  err_inc;
  logic [GOOD_W-1:0] good_next;

  vita49_pps_sync u_pps_sync (
    .clk      (samp_clk),
    .rst_n    (ARESETN),
    .pps      (pps),
    .pps_rise (pps_rise)
  );

  assign mode = bus.freerun ? FREERUN : DISC;

  always_comb begin
    epoch_now = 1'b0;
    holdover  = 1'b0;
    case (mode)
      FREERUN: epoch_now = (tsf_q == NOM_LAST);
      DISC: begin
        holdover  = (tsf_q == HOLD_LAST) & ~pps_rise;
        epoch_now = pps_rise | holdover;
      end
      default: ;
    endcase
  end

  // Measured period is tsf+1, so the window is applied to tsf shifted by one.
  assign period_ok = (tsf_q >= WIN_LO) && (tsf_q <= WIN_HI);

  // A simultaneous err_clr only removes the history; a new error still counts.
  always_comb begin
    err_base = bus.err_clr ? '0 : err_cnt_q;
    err_inc  = (&err_base) ? err_base : err_base + ERR_W'(1);
  end

  assign good_next = (good_q == GOOD_W'(LOCK_CNT)) ? good_q : good_q + GOOD_W'(1);

  always_ff @(posedge samp_clk or negedge ARESETN) begin
    if (!ARESETN) begin
      tsi_q   <= '0;
      tsf_q   <= '0;
      pend_q  <= '0;
      armed_q <= 1'b0;
      epoch_q <= 1'b0;
    end else if (bus.clr) begin
      tsi_q   <= '0;
      tsf_q   <= '0;
      pend_q  <= '0;
      armed_q <= 1'b0;
      epoch_q <= 1'b0;
    end else if (!bus.en) begin
      epoch_q <= 1'b0;
      if (bus.set_tsi) begin
        tsi_q   <= bus.tsi_prog;
        armed_q <= 1'b0;
      end
    end else begin
      if (epoch_now) begin
        tsf_q   <= '0;
        tsi_q   <= armed_q ? pend_q : tsi_q + TSI_W'(1);
        armed_q <= 1'b0;
        epoch_q <= 1'b1;
      end else begin
        tsf_q   <= tsf_q + TSF_W'(1);
        epoch_q <= 1'b0;
      end
      // Placed after the epoch update so a same-cycle request arms the next epoch.
      if (bus.set_tsi) begin
        pend_q  <= bus.tsi_prog;
        armed_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge samp_clk or negedge ARESETN) begin
    if (!ARESETN) begin
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      miss_q    <= 1'b0;
      err_cnt_q <= '0;
      good_q    <= '0;
      aligned_q <= 1'b0;
    end else if (bus.clr) begin
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      miss_q    <= 1'b0;
      err_cnt_q <= '0;
      good_q    <= '0;
      aligned_q <= 1'b0;
    end else begin
      if (bus.err_clr) begin
        err_q     <= 1'b0;
        miss_q    <= 1'b0;
        err_cnt_q <= '0;
      end
      if (!bus.en) begin
        aligned_q <= 1'b0;
      end else if (holdover) begin
        miss_q    <= 1'b1;
        err_cnt_q <= err_inc;
        lock_q    <= 1'b0;
        good_q    <= '0;
        aligned_q <= 1'b0;
      end else if (pps_rise) begin
        if (!aligned_q) begin
          aligned_q <= 1'b1;
        end else if (period_ok) begin
          good_q <= good_next;
          lock_q <= (good_next == GOOD_W'(LOCK_CNT));
        end else begin
          err_q     <= 1'b1;
          err_cnt_q <= err_inc;
          good_q    <= '0;
          lock_q    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge samp_clk or negedge ARESETN) begin
    if (!ARESETN) begin
      snap_tsi_q   <= '0;
      snap_tsf_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= bus.snap_req;
      if (bus.snap_req) begin
        snap_tsi_q <= tsi_q;
        snap_tsf_q <= tsf_q;
      end
    end
  end

  assign bus.tsi        = tsi_q;
  assign bus.tsf        = tsf_q;
  assign bus.epoch      = epoch_q;
  assign bus.snap_tsi   = snap_tsi_q;
  assign bus.snap_tsf   = snap_tsf_q;
  assign bus.snap_valid = snap_valid_q;
  assign bus.armed      = armed_q;
  assign bus.pps_lock   = lock_q;
  assign bus.pps_err    = err_q;
  assign bus.pps_miss   = miss_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule
